// File: rtl/rob_reorder_buffer.sv
// rtl/rob_reorder_buffer.sv - in-order retirement reorder buffer with out-of-order completion
// Optional same-cycle completion bypass at the head: ROB_CMPL_BYPASS_EN
module rob_reorder_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  cmpl_valid,
  input  logic [TAG_WIDTH-1:0]  cmpl_tag,
  input  logic [DATA_WIDTH-1:0] cmpl_data,
  output logic                  out_valid,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [TAG_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  cmpl_err
);

  localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]      alloc_q;
  logic [DEPTH-1:0]      done_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [TAG_WIDTH-1:0]  head_q;
  logic [TAG_WIDTH-1:0]  tail_q;
  logic [TAG_WIDTH:0]    count_q;
  logic                  cmpl_err_q;
  logic                  cmpl_ok;
  logic                  head_done;
  logic                  pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign cmpl_err  = cmpl_err_q;
  assign alloc_gnt = alloc_req && !full;
  assign alloc_tag = tail_q;
  assign out_tag   = head_q;

  // A completion is legal only for an allocated entry that has not completed yet.
  assign cmpl_ok   = cmpl_valid && alloc_q[cmpl_tag] && !done_q[cmpl_tag];
  assign head_done = alloc_q[head_q] && done_q[head_q];

`ifdef ROB_CMPL_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = cmpl_ok && (cmpl_tag == head_q);
  assign out_valid  = head_done || bypass_hit;
  assign out_data   = head_done ? data_q[head_q] : cmpl_data;
`else
  assign out_valid  = head_done;
  assign out_data   = data_q[head_q];
`endif

  assign pop = out_valid && out_ready;

  // Pop is applied last so a bypassed head retires with done left clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q    <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cmpl_err_q <= 1'b0;
    end else begin
      if (alloc_gnt) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      if (cmpl_ok) begin
        done_q[cmpl_tag] <= 1'b1;
      end
      if (pop) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      cmpl_err_q <= cmpl_valid && !cmpl_ok;
      case ({alloc_gnt, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cmpl_ok) begin
      data_q[cmpl_tag] <= cmpl_data;
    end
  end

endmodule
